// File: rtl/decryption_scheduler.sv
// Front-end scheduler: collects one serial message, forwards it to the selected
// decryption engine, waits for that engine to finish and muxes its output.
module decryption_scheduler #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
    parameter int                 BUSY_TIMEOUT           = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [D_WIDTH-1:0]     data_i,
    input  logic                   valid_i,
    input  logic [1:0]             sel_i,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [D_WIDTH-1:0]     eng_data_o,
    output logic [2:0]             eng_valid_o,
    input  logic [2:0]             eng_busy_i,
    input  logic [3*D_WIDTH-1:0]   eng_data_i,
    input  logic [2:0]             eng_valid_i,
    output logic [D_WIDTH-1:0]     data_o,
    output logic                   valid_o
);

    localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NOF_CHARS);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(BUSY_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DISCARD, S_START, S_RUN, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [D_WIDTH-1:0] eng_data_q, eng_data_d;
    logic [2:0]         eng_valid_q, eng_valid_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               fwd;
    logic [1:0]         fwd_sel;
    logic               eng_busy_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            eng_data_q  <= '0;
            eng_valid_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            eng_data_q  <= eng_data_d;
            eng_valid_q <= eng_valid_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    // Any input arriving while an engine owns the message is a protocol error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        fwd     = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (data_i == START_DECRYPTION_TOKEN) begin
                        err_d = 1'b1;
                    end else if (sel_i != 2'd3) begin
                        sel_d   = sel_i;
                        fwd     = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = S_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
            end
            S_LOAD: begin
                if (valid_i) begin
                    if (data_i == START_DECRYPTION_TOKEN) begin
                        fwd     = 1'b1;
                        timer_d = '0;
                        state_d = S_START;
                    end else if (cnt_q < CNT_MAX) begin
                        fwd   = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DISCARD: begin
                if (valid_i && (data_i == START_DECRYPTION_TOKEN)) begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                err_d = valid_i;
                if (eng_busy_sel) begin
                    state_d = S_RUN;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if ((timer_q + TMR_W'(1)) == TMR_MAX) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                err_d = valid_i;
                if (!eng_busy_sel) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                err_d   = valid_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The first character forwards with the fresh select; later ones use the latched one.
    always_comb begin
        fwd_sel      = (state_q == S_IDLE) ? sel_i : sel_q;
        eng_valid_d  = fwd ? (3'b001 << fwd_sel) : 3'b000;
        eng_data_d   = fwd ? data_i : eng_data_q;
        busy_d       = (state_d == S_START) || (state_d == S_RUN) || (state_d == S_DONE);
        data_d       = eng_data_i[D_WIDTH-1:0];
        valid_d      = eng_valid_i[0];
        eng_busy_sel = eng_busy_i[0];
        case (sel_q)
            2'd1: begin
                data_d       = eng_data_i[D_WIDTH +: D_WIDTH];
                valid_d      = eng_valid_i[1];
                eng_busy_sel = eng_busy_i[1];
            end
            2'd2: begin
                data_d       = eng_data_i[2*D_WIDTH +: D_WIDTH];
                valid_d      = eng_valid_i[2];
                eng_busy_sel = eng_busy_i[2];
            end
            default: ;
        endcase
    end

    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign eng_data_o  = eng_data_q;
    assign eng_valid_o = eng_valid_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_decryption_scheduler.sv
// Scoreboard bench for decryption_scheduler: directed messages push expected
// forwards and engine outputs into queues that negedge monitors pop and compare.
module tb_decryption_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [1:0]  sel_i;
    logic        busy_o;
    logic        err_o;
    logic [7:0]  eng_data_o;
    logic [2:0]  eng_valid_o;
    logic [2:0]  eng_busy_i;
    logic [23:0] eng_data_i;
    logic [2:0]  eng_valid_i;
    logic [7:0]  data_o;
    logic        valid_o;

    typedef struct {
        logic [2:0] v;
        logic [7:0] d;
        int         c;
    } fwd_t;

    typedef struct {
        logic [7:0] d;
        int         c;
    } out_t;

    fwd_t fwdQ[$];
    out_t outQ[$];

    int compared     = 0;
    int mismatched   = 0;
    int cyc          = 0;
    int errCount     = 0;
    int expErr       = 0;
    int lastErrCycle = -1;
    int tokenCyc;

    decryption_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .sel_i       (sel_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .eng_data_o  (eng_data_o),
        .eng_valid_o (eng_valid_o),
        .eng_busy_i  (eng_busy_i),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitors pop the scoreboard whenever the DUT presents a forward or an output.
    always @(negedge clk) begin
        fwd_t f;
        out_t o;
        if (rst_n) begin
            if (eng_valid_o != 3'b000) begin
                compared++;
                if (fwdQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL fwd_unexpected: got valid=%b data=0x%0h, expected no forward (cycle %0d)",
                             eng_valid_o, eng_data_o, cyc);
                end else begin
                    f = fwdQ.pop_front();
                    if (f.v !== eng_valid_o || f.d !== eng_data_o || f.c != cyc) begin
                        mismatched++;
                        $display("[TB] FAIL fwd: got valid=%b data=0x%0h cycle=%0d, expected valid=%b data=0x%0h cycle=%0d",
                                 eng_valid_o, eng_data_o, cyc, f.v, f.d, f.c);
                    end
                end
            end
            if (valid_o) begin
                compared++;
                if (outQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL out_unexpected: got data_o=0x%0h, expected no output (cycle %0d)", data_o, cyc);
                end else begin
                    o = outQ.pop_front();
                    if (o.d !== data_o || o.c != cyc) begin
                        mismatched++;
                        $display("[TB] FAIL out: got data_o=0x%0h cycle=%0d, expected 0x%0h cycle=%0d",
                                 data_o, cyc, o.d, o.c);
                    end
                end
            end
            if (err_o) begin
                errCount++;
                lastErrCycle = cyc;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleNeg();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] s, input logic [2:0] expV);
        data_i  = d;
        sel_i   = s;
        valid_i = 1'b1;
        if (expV != 3'b000) fwdQ.push_back('{v: expV, d: d, c: cyc + 1});
        cycle();
        valid_i = 1'b0;
    endtask

    task automatic engOut(input int k, input logic [7:0] d, input bit expected);
        eng_data_i[k*8 +: 8] = d;
        eng_valid_i[k]       = 1'b1;
        if (expected) outQ.push_back('{d: d, c: cyc + 1});
    endtask

    // Called right after the token edge; engine k holds busy for six cycles.
    task automatic engineSession(input int k, input bit pokeInput);
        int other;
        other = (k + 2) % 3;
        eng_busy_i[k] = 1'b1;
        sampleNeg();
        checkOutput("busy_after_token", 32'(busy_o), 32'd1);
        cycle();
        engOut(k, 8'(8'h60 + k), 1'b1);
        engOut(other, 8'hEE, 1'b0);
        cycle();
        eng_valid_i = 3'b000;
        if (pokeInput) begin
            data_i  = 8'h5A;
            sel_i   = 2'(k);
            valid_i = 1'b1;
            expErr++;
        end
        cycle();
        valid_i = 1'b0;
        repeat (3) cycle();
        eng_busy_i[k] = 1'b0;
        engOut(k, 8'(8'h70 + k), 1'b1);
        sampleNeg();
        checkOutput("busy_run_last", 32'(busy_o), 32'd1);
        cycle();
        eng_valid_i = 3'b000;
        sampleNeg();
        checkOutput("busy_done", 32'(busy_o), 32'd1);
        cycle();
        sampleNeg();
        checkOutput("busy_idle", 32'(busy_o), 32'd0);
        checkOutput("err_count", 32'(errCount), 32'(expErr));
        cycle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy_o"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_err_o"}, 32'(err_o), 32'd0);
        checkOutput({tag, "_eng_data_o"}, 32'(eng_data_o), 32'd0);
        checkOutput({tag, "_eng_valid_o"}, 32'(eng_valid_o), 32'd0);
        checkOutput({tag, "_data_o"}, 32'(data_o), 32'd0);
        checkOutput({tag, "_valid_o"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        data_i      = '0;
        valid_i     = 1'b0;
        sel_i       = '0;
        eng_busy_i  = '0;
        eng_data_i  = '0;
        eng_valid_i = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        cycle();

        $display("[TB] normal path, engine 1");
        applyStimulus("A", 2'd1, 3'b010);
        applyStimulus("B", 2'd1, 3'b010);
        applyStimulus("C", 2'd1, 3'b010);
        applyStimulus("D", 2'd1, 3'b010);
        checkOutput("busy_before_token", 32'(busy_o), 32'd0);
        applyStimulus(8'hFA, 2'd1, 3'b010);
        engineSession(1, 1'b0);

        $display("[TB] select latched on first character");
        applyStimulus("a", 2'd0, 3'b001);
        applyStimulus("b", 2'd2, 3'b001);
        applyStimulus("c", 2'd2, 3'b001);
        applyStimulus(8'hFA, 2'd2, 3'b001);
        engineSession(0, 1'b0);

        $display("[TB] empty message");
        applyStimulus(8'hFA, 2'd0, 3'b000);
        expErr++;
        sampleNeg();
        checkOutput("err_empty", 32'(errCount), 32'(expErr));
        cycle();

        $display("[TB] illegal select");
        applyStimulus("X", 2'd3, 3'b000);
        expErr++;
        applyStimulus("Y", 2'd3, 3'b000);
        applyStimulus(8'hFA, 2'd3, 3'b000);
        sampleNeg();
        checkOutput("err_illegal_sel", 32'(errCount), 32'(expErr));
        cycle();
        applyStimulus("h", 2'd2, 3'b100);
        applyStimulus("i", 2'd2, 3'b100);
        applyStimulus(8'hFA, 2'd2, 3'b100);
        engineSession(2, 1'b0);

        $display("[TB] overflow");
        for (int i = 0; i < 51; i++) begin
            applyStimulus(8'(8'h20 + i), 2'd0, (i < 50) ? 3'b001 : 3'b000);
        end
        expErr++;
        applyStimulus(8'hFA, 2'd0, 3'b001);
        engineSession(0, 1'b0);

        $display("[TB] busy timeout");
        applyStimulus("Q", 2'd1, 3'b010);
        applyStimulus(8'hFA, 2'd1, 3'b010);
        tokenCyc = cyc;
        sampleNeg();
        checkOutput("busy_start", 32'(busy_o), 32'd1);
        repeat (3) cycle();
        sampleNeg();
        checkOutput("busy_start_last", 32'(busy_o), 32'd1);
        checkOutput("err_before_timeout", 32'(errCount), 32'(expErr));
        cycle();
        expErr++;
        sampleNeg();
        checkOutput("busy_after_timeout", 32'(busy_o), 32'd0);
        checkOutput("err_timeout_count", 32'(errCount), 32'(expErr));
        checkOutput("err_timeout_cycle", 32'(lastErrCycle), 32'(tokenCyc + 4));
        cycle();

        $display("[TB] input during run");
        applyStimulus("r", 2'd2, 3'b100);
        applyStimulus(8'hFA, 2'd2, 3'b100);
        engineSession(2, 1'b1);

        $display("[TB] reset mid-run");
        applyStimulus("m", 2'd0, 3'b001);
        applyStimulus(8'hFA, 2'd0, 3'b001);
        eng_busy_i[0] = 1'b1;
        cycle();
        cycle();
        checkOutput("busy_in_run", 32'(busy_o), 32'd1);
        #2;
        rst_n       = 1'b0;
        eng_busy_i  = '0;
        eng_valid_i = '0;
        #1;
        checkAllZero("midrun_reset");
        cycle();
        rst_n = 1'b1;
        cycle();
        applyStimulus("n", 2'd1, 3'b010);
        applyStimulus("o", 2'd1, 3'b010);
        applyStimulus(8'hFA, 2'd1, 3'b010);
        engineSession(1, 1'b0);

        repeat (3) cycle();
        checkOutput("fwd_queue_drained", 32'(fwdQ.size()), 32'd0);
        checkOutput("out_queue_drained", 32'(outQ.size()), 32'd0);
        checkOutput("err_final", 32'(errCount), 32'(expErr));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
